// File: rtl/vga_fb_arbiter.sv
// Frame-buffer port arbiter: VGA prefetch FIFO vs. image-processing writer.
// Optional FB_ARB_STATS_EN adds writer-stall and minimum-FIFO-level stats.
module vga_fb_arbiter #(
    parameter int          H_RES         = 640,
    parameter int          V_RES         = 480,
    parameter int          PIX_W         = 12,
    parameter int          ADDR_W        = 19,
    parameter int          FIFO_DEPTH    = 16,
    parameter int          LOW_WM        = 4,
    parameter logic [11:0] UNDERFLOW_PIX = 12'hF0F
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              vs,
    input  logic [9:0]        hc_visible,
    input  logic [9:0]        vc_visible,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_we,
    output logic [PIX_W-1:0]  fb_wdata,
    input  logic [PIX_W-1:0]  fb_rdata,
    output logic [PIX_W-1:0]  pix_out,
    output logic              underflow
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       wr_stall_cnt,
    output logic [$clog2(FIFO_DEPTH):0] min_level
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

    typedef enum logic [1:0] {S_BLANK, S_RUN, S_DONE} state_t;

    state_t            state_q;
    logic [PIX_W-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q;
    logic [ADDR_W-1:0] fetch_addr_q, hold_addr_q;
    logic              in_flight_q;
    logic [PIX_W-1:0]  pix_q;
    logic              unf_q;

    logic          pop, pop_ok, run, fetch_ok, low;
    logic          do_fetch, do_write;
    logic [LW:0]   occ;

    assign pop    = (hc_visible != 10'd0) && (vc_visible != 10'd0);
    assign pop_ok = pop && (level_q != '0);
    assign run    = (state_q == S_RUN) && vs;
    assign occ    = {1'b0, level_q} + {{LW{1'b0}}, in_flight_q};
    assign fetch_ok = occ < (LW+1)'(FIFO_DEPTH);
    assign low    = level_q < LW'(LOW_WM);

    // Grants are forced off while reset is held so every output reads 0.
    always_comb begin
        do_fetch = 1'b0;
        do_write = 1'b0;
        if (rst) begin
            if (run) begin
                if (fetch_ok && low)  do_fetch = 1'b1;
                else if (wr_valid)    do_write = 1'b1;
                else if (fetch_ok)    do_fetch = 1'b1;
            end else begin
                do_write = wr_valid;
            end
        end
    end

    assign wr_ready  = do_write;
    assign fb_we     = do_write;
    assign fb_wdata  = do_write ? wr_data : '0;
    assign fb_addr   = do_write ? wr_addr :
                       do_fetch ? fetch_addr_q : hold_addr_q;
    assign pix_out   = pix_q;
    assign underflow = unf_q;

    always_ff @(posedge clk_vga) begin
        if (in_flight_q) mem_q[wptr_q] <= fb_rdata;
    end

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            state_q      <= S_BLANK;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            fetch_addr_q <= '0;
            hold_addr_q  <= '0;
            in_flight_q  <= 1'b0;
            pix_q        <= '0;
            unf_q        <= 1'b0;
        end else begin
            if (do_write)      hold_addr_q <= wr_addr;
            else if (do_fetch) hold_addr_q <= fetch_addr_q;

            if (!pop)    pix_q <= '0;
            else if (pop_ok) pix_q <= mem_q[rptr_q];
            else         pix_q <= UNDERFLOW_PIX;

            if (!vs) begin
                state_q      <= S_BLANK;
                wptr_q       <= '0;
                rptr_q       <= '0;
                level_q      <= '0;
                fetch_addr_q <= '0;
                in_flight_q  <= 1'b0;
                unf_q        <= 1'b0;
            end else begin
                if (pop && !pop_ok) unf_q <= 1'b1;
                if (in_flight_q) wptr_q <= wptr_q + 1'b1;
                if (pop_ok)      rptr_q <= rptr_q + 1'b1;
                unique case ({in_flight_q, pop_ok})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
                in_flight_q <= do_fetch;
                if (do_fetch) fetch_addr_q <= fetch_addr_q + 1'b1;
                unique case (state_q)
                    S_BLANK: state_q <= S_RUN;
                    S_RUN: begin
                        if (do_fetch && fetch_addr_q == LAST_ADDR)
                            state_q <= S_DONE;
                    end
                    default: state_q <= state_q;
                endcase
            end
        end
    end

`ifdef FB_ARB_STATS_EN
    logic [15:0] stall_q;
    logic [LW-1:0] min_q;

    assign wr_stall_cnt = stall_q;
    assign min_level    = min_q;

    always_ff @(posedge clk_vga or negedge rst) begin
        if (!rst) begin
            stall_q <= '0;
            min_q   <= LW'(FIFO_DEPTH);
        end else if (!vs || state_q == S_BLANK) begin
            stall_q <= '0;
            min_q   <= LW'(FIFO_DEPTH);
        end else begin
            if (run && wr_valid && !do_write && stall_q != 16'hFFFF)
                stall_q <= stall_q + 1'b1;
            if (pop && level_q < min_q) min_q <= level_q;
        end
    end
`endif

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter with a data=addr RAM model.
// Uses a short 640x8 frame so a whole frame fits in a quick run.
module tb_vga_fb_arbiter;

    localparam int H_RES  = 640;
    localparam int V_RES  = 8;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 19;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              vs = 1'b0;
    logic [9:0]        hc = '0;
    logic [9:0]        vc = '0;
    logic              wr_valid = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [PIX_W-1:0]  wr_data = '0;
    logic              wr_ready;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_we;
    logic [PIX_W-1:0]  fb_wdata;
    logic [PIX_W-1:0]  fb_rdata = '0;
    logic [PIX_W-1:0]  pix_out;
    logic              underflow;

    int n_cmp = 0;
    int n_bad = 0;
    int pix_cnt = 0;
    logic [11:0] exp_q[$];

    always #20 clk = ~clk;

    always @(posedge clk) fb_rdata <= fb_addr[11:0];

    vga_fb_arbiter #(
        .H_RES(H_RES), .V_RES(V_RES), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
        .FIFO_DEPTH(16), .LOW_WM(4), .UNDERFLOW_PIX(12'hF0F)
    ) dut (
        .clk_vga(clk), .rst(rst), .vs(vs),
        .hc_visible(hc), .vc_visible(vc),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .fb_addr(fb_addr), .fb_we(fb_we),
        .fb_wdata(fb_wdata), .fb_rdata(fb_rdata),
        .pix_out(pix_out), .underflow(underflow)
    );

    task automatic drive(input logic v, input logic [9:0] h,
                         input logic [9:0] c, input logic w);
        @(negedge clk);
        vs = v; hc = h; vc = c; wr_valid = w;
        #1;
    endtask

    task automatic refill();
        drive(1'b0, 10'd0, 10'd0, 1'b0);
        drive(1'b1, 10'd0, 10'd0, 1'b0);
        repeat (20) drive(1'b1, 10'd0, 10'd0, 1'b0);
        pix_cnt = 0;
    endtask

    task automatic test_reset();
        wr_valid = 1'b1;
        wr_addr  = 19'h1234;
        wr_data  = 12'h777;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (pix_out !== 12'h0) begin n_bad++;
            $display("FAIL reset_pix got %h want 000", pix_out); end
        n_cmp++; if (underflow !== 1'b0) begin n_bad++;
            $display("FAIL reset_unf got %b want 0", underflow); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_bad++;
            $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++;
            $display("FAIL reset_fb_we got %b want 0", fb_we); end
        n_cmp++; if (fb_addr !== 19'h0) begin n_bad++;
            $display("FAIL reset_fb_addr got %h want 0", fb_addr); end
        n_cmp++; if (fb_wdata !== 12'h0) begin n_bad++;
            $display("FAIL reset_fb_wdata got %h want 0", fb_wdata); end
        wr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_prefill();
        drive(1'b1, 10'd0, 10'd0, 1'b0);
        n_cmp++; if (fb_we !== 1'b0) begin n_bad++;
            $display("FAIL prefill_blank_we got %b want 0", fb_we); end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 10'd0, 10'd0, 1'b0);
            n_cmp++; if (fb_addr !== 19'(i) || fb_we !== 1'b0) begin n_bad++;
                $display("FAIL prefill_fetch%0d got addr %h we %b want addr %h we 0",
                         i, fb_addr, fb_we, 19'(i)); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'd0, 10'd0, 1'b0);
            n_cmp++; if (fb_addr !== 19'd15 || fb_we !== 1'b0) begin n_bad++;
                $display("FAIL prefill_full_idle got addr %h we %b want addr 00f we 0",
                         fb_addr, fb_we); end
        end
        pix_cnt = 0;
    endtask

    task automatic test_pop_run(input int n);
        logic [11:0] e;
        for (int i = 0; i <= n; i++) begin
            if (i < n) drive(1'b1, 10'((i % H_RES) + 1), 10'((i / H_RES) + 1), 1'b0);
            else       drive(1'b1, 10'd0, 10'd0, 1'b0);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (pix_out !== e) begin n_bad++;
                    $display("FAIL pix_seq got %h want %h", pix_out, e); end
            end
            if (i < n) begin
                exp_q.push_back(pix_cnt[11:0]);
                pix_cnt++;
            end
        end
        drive(1'b1, 10'd0, 10'd0, 1'b0);
        n_cmp++; if (pix_out !== 12'h0) begin n_bad++;
            $display("FAIL pix_nopop got %h want 000", pix_out); end
        n_cmp++; if (underflow !== 1'b0) begin n_bad++;
            $display("FAIL pix_run_unf got %b want 0", underflow); end
    endtask

    task automatic test_writer();
        logic [11:0] e;
        refill();
        wr_addr = 19'h12345;
        wr_data = 12'hABC;
        drive(1'b1, 10'd0, 10'd0, 1'b1);
        n_cmp++; if (wr_ready !== 1'b1 || fb_we !== 1'b1) begin n_bad++;
            $display("FAIL wr_grant got rdy %b we %b want 1 1", wr_ready, fb_we); end
        n_cmp++; if (fb_addr !== 19'h12345 || fb_wdata !== 12'hABC) begin n_bad++;
            $display("FAIL wr_bus got %h/%h want 12345/abc", fb_addr, fb_wdata); end
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 10'(k + 1), 10'd1, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++; if (pix_out !== e) begin n_bad++;
                    $display("FAIL wr_pix got %h want %h", pix_out, e); end
            end
            n_cmp++; if (wr_ready !== (k < 13)) begin n_bad++;
                $display("FAIL wr_drain%0d got rdy %b want %b", k, wr_ready, k < 13); end
            if (k == 13) begin
                n_cmp++; if (fb_addr !== 19'd16 || fb_we !== 1'b0) begin n_bad++;
                    $display("FAIL wr_preempt got addr %h we %b want 010 0",
                             fb_addr, fb_we); end
            end
            exp_q.push_back(pix_cnt[11:0]);
            pix_cnt++;
        end
        drive(1'b1, 10'd0, 10'd0, 1'b0);
        e = exp_q.pop_front();
        n_cmp++; if (pix_out !== e) begin n_bad++;
            $display("FAIL wr_pix_last got %h want %h", pix_out, e); end
    endtask

    task automatic test_underflow();
        drive(1'b0, 10'd0, 10'd0, 1'b0);
        drive(1'b1, 10'd5, 10'd1, 1'b0);
        drive(1'b1, 10'd0, 10'd0, 1'b0);
        n_cmp++; if (pix_out !== 12'hF0F) begin n_bad++;
            $display("FAIL unf_pix got %h want f0f", pix_out); end
        n_cmp++; if (underflow !== 1'b1) begin n_bad++;
            $display("FAIL unf_set got %b want 1", underflow); end
        repeat (3) drive(1'b1, 10'd0, 10'd0, 1'b0);
        n_cmp++; if (underflow !== 1'b1 || pix_out !== 12'h0) begin n_bad++;
            $display("FAIL unf_sticky got %b pix %h want 1 000", underflow, pix_out); end
        drive(1'b0, 10'd0, 10'd0, 1'b0);
        drive(1'b1, 10'd0, 10'd0, 1'b0);
        n_cmp++; if (underflow !== 1'b0) begin n_bad++;
            $display("FAIL unf_clear got %b want 0", underflow); end
        repeat (20) drive(1'b1, 10'd0, 10'd0, 1'b0);
        pix_cnt = 0;
    endtask

    task automatic test_frame();
        refill();
        test_pop_run(H_RES * V_RES);
        wr_addr = 19'h40000;
        wr_data = 12'h5A5;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 10'd0, 10'd0, 1'b1);
            n_cmp++; if (wr_ready !== 1'b1 || fb_we !== 1'b1) begin n_bad++;
                $display("FAIL done_wr%0d got rdy %b we %b want 1 1", i, wr_ready, fb_we); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 10'd0, 10'd0, 1'b0);
            n_cmp++; if (fb_we !== 1'b0 || fb_addr !== 19'h40000) begin n_bad++;
                $display("FAIL done_noread got addr %h we %b want 40000 0", fb_addr, fb_we); end
        end
    endtask

    task automatic test_async_reset();
        drive(1'b0, 10'd0, 10'd0, 1'b0);
        drive(1'b1, 10'd5, 10'd1, 1'b1);
        n_cmp++; if (wr_ready !== 1'b1) begin n_bad++;
            $display("FAIL blank_writer got %b want 1", wr_ready); end
        drive(1'b1, 10'd3, 10'd1, 1'b1);
        n_cmp++; if (fb_addr !== 19'd0 || wr_ready !== 1'b0) begin n_bad++;
            $display("FAIL ar_fetch0 got addr %h rdy %b want 0 0", fb_addr, wr_ready); end
        drive(1'b1, 10'd0, 10'd0, 1'b1);
        n_cmp++; if (fb_addr !== 19'd1 || pix_out !== 12'hF0F) begin n_bad++;
            $display("FAIL ar_fetch1 got addr %h pix %h want 1 f0f", fb_addr, pix_out); end
        #5 rst = 1'b0;
        #1;
        n_cmp++; if (pix_out !== 12'h0 || underflow !== 1'b0) begin n_bad++;
            $display("FAIL ar_regs got pix %h unf %b want 000 0", pix_out, underflow); end
        n_cmp++; if (wr_ready !== 1'b0 || fb_we !== 1'b0) begin n_bad++;
            $display("FAIL ar_grant got rdy %b we %b want 0 0", wr_ready, fb_we); end
        n_cmp++; if (fb_addr !== 19'h0 || fb_wdata !== 12'h0) begin n_bad++;
            $display("FAIL ar_bus got %h/%h want 0/0", fb_addr, fb_wdata); end
        wr_valid = 1'b0;
        repeat (2) @(negedge clk);
        vs = 1'b0; hc = '0; vc = '0;
        rst = 1'b1;
        test_prefill();
        test_pop_run(20);
    endtask

    initial begin
        test_reset();
        test_prefill();
        test_pop_run(H_RES);
        test_writer();
        test_underflow();
        test_frame();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port frame-buffer RAM between two users: the VGA scan-out path and an image-processing writer.
- Keeps a small prefetch FIFO of display pixels, paced by the 640x480 timing generator's hc_visible/vc_visible/vs outputs.
- Display fetches take priority only when the FIFO runs low; otherwise the writer gets the port.
- Sits between the VGA timing driver, the frame-buffer BRAM and the processing pipeline, in the clk_vga domain.

Parameters:
- H_RES, 640, visible pixels per line.
- V_RES, 480, visible lines per frame.
- PIX_W, 12, pixel width (RGB444).
- ADDR_W, 19, frame-buffer address width; must hold H_RES*V_RES.
- FIFO_DEPTH, 16, prefetch FIFO entries; power of 2, at least 4.
- LOW_WM, 4, level below which display fetch preempts the writer.
- UNDERFLOW_PIX, 12'hF0F, pixel driven on underflow.

Ports:
- clk_vga  in  1  pixel clock, 25 MHz.
- rst  in  1  asynchronous active-low reset.
- vs  in  1  vertical sync from the timing driver; low means vertical sync pulse.
- hc_visible  in  10  0 means blanking; 1..H_RES means visible column.
- vc_visible  in  10  0 means blanking; 1..V_RES means visible line.
- wr_valid  in  1  writer request.
- wr_addr  in  ADDR_W  writer address.
- wr_data  in  PIX_W  writer data.
- wr_ready  out  1  writer granted this cycle.
- fb_addr  out  ADDR_W  RAM address.
- fb_we  out  1  RAM write enable.
- fb_wdata  out  PIX_W  RAM write data.
- fb_rdata  in  PIX_W  RAM read data, valid 1 cycle after the read address.
- pix_out  out  PIX_W  registered display pixel.
- underflow  out  1  sticky underflow flag, cleared at frame start.

Behaviour:
- Reset values: all outputs 0; FSM in S_BLANK; FIFO empty; fetch_addr=0; in_flight=0.
- Pop condition: pop = (hc_visible!=0 && vc_visible!=0).
- Pop timing: on pop, pix_out gets the FIFO head on the next clk_vga edge, so pix_out lags the pop cycle by 1.
- No pop: pix_out=0.
- Pop with FIFO empty: pix_out=UNDERFLOW_PIX and underflow is set; FIFO state is unchanged.
- FSM S_BLANK:
  - Entered whenever vs==0, from any state.
  - Clears FIFO, fetch_addr, in_flight (a returning read is discarded) and underflow.
  - Writer owns the port.
  - Exit to S_RUN when vs==1.
- FSM S_RUN:
  - fetch_ok = (level + in_flight < FIFO_DEPTH).
  - Arbitration, evaluated each cycle, exactly one grant:
    - If fetch_ok && level < LOW_WM: fetch.
    - Else if wr_valid: write.
    - Else if fetch_ok: fetch.
    - Else idle.
  - Fetch: fb_addr=fetch_addr, fb_we=0, fetch_addr+1, in_flight=1; the next cycle pushes fb_rdata into the FIFO.
  - Go to S_DONE when fetch_addr reaches H_RES*V_RES-1 and that fetch is issued.
- FSM S_DONE: no fetches; the writer owns the port until vs==0.
- Write grant: wr_ready=1 combinationally in the granted cycle; fb_addr=wr_addr, fb_we=1, fb_wdata=wr_data.
- Writer stall: the writer is held (wr_ready=0) while display priority applies; wr_* must stay stable until wr_ready.
- Idle port: fb_we=0, fb_addr holds its last value.
- Simultaneous push and pop: level is unchanged; both operations are legal when full-minus-one or when level is 1.
- Simultaneous pop-on-empty and push: the pushed data is stored, underflow is set, and pix_out=UNDERFLOW_PIX (no bypass).
- Level counter: width clog2(FIFO_DEPTH)+1; it never exceeds FIFO_DEPTH because of the fetch_ok guard.
- Read data: combinational pass-through from the RAM; no extra pipeline stage.

Optional Feature:
- Macro: FB_ARB_STATS_EN.
- Defined:
  - Adds output wr_stall_cnt[15:0]: a saturating count of cycles with wr_valid=1 && wr_ready=0 in S_RUN.
  - Adds output min_level[$clog2(FIFO_DEPTH):0]: the minimum FIFO level seen while pop=1.
  - Both reset in S_BLANK; min_level resets to FIFO_DEPTH.
- Undefined: neither port nor logic exists; all other behaviour is identical.

Test Plan:
- Reset, then vs=1 with hc/vc blank and wr_valid=0 -> 16 fetches issued at fb_addr 0..15 on consecutive cycles, FIFO level=16, fb_we=0 throughout.
- RAM model returns data=addr[11:0]; drive a visible line of 640 pops -> pix_out sequence 0,1,2,...,639, one cycle after each pop; underflow=0.
- wr_valid held high with level>=LOW_WM -> wr_ready=1 and fb_we=1 at wr_addr; when pops drain level to 3 -> next grant is a fetch, wr_ready=0 for that cycle.
- Stop the RAM model from feeding by holding the FIFO empty via a forced flush (vs pulse mid-line), then pop with hc_visible=5 -> pix_out=12'hF0F, underflow=1; the next vs low clears underflow.
- Complete a frame of 307200 fetches -> FSM in S_DONE, no reads until vs=0; writer is granted every cycle with wr_valid=1.
- Assert rst low mid-fetch with in_flight=1 -> all outputs 0 immediately (asynchronous), and no FIFO push occurs after release.
